command_sequencer: RTL and testbench

Program-driven command source sitting directly upstream of the ALU controller. It holds a small program of 12-bit commands, steps through it with a program counter, and presents one command at a time to the controller over a valid/ready handshake. Execution stops at a HALT opcode, at the end of program memory, or on an external stop request.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/command_store.sv | 29 ++
 rtl/command_sequencer.sv | 100 ++++++++++
 tb/tb_command_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared command encoding and sequencer state types for the ALU controller path.
package alu_pkg;
    localparam int CMD_W  = 12;
    localparam int OP_MSB = 11;
    localparam int OP_LSB = 9;
    localparam int A1_MSB = 8;
    localparam int A1_LSB = 6;
    localparam int A2_MSB = 5;
    localparam int A2_LSB = 3;
    localparam int A3_MSB = 2;
    localparam int A3_LSB = 0;

    localparam logic [CMD_W-1:0] HALT_CMD = 12'hE00;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_NOT  = 3'b100,
        OP_NOP1 = 3'b101,
        OP_NOP2 = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic logic is_halt(input logic [CMD_W-1:0] c);
        return opcode_t'(c[OP_MSB:OP_LSB]) == OP_HALT;
    endfunction
endpackage

// File: rtl/command_store.sv
// Program memory: register array, one synchronous write port, one combinational
// read port, cleared to HALT on reset so an unloaded program completes at once.
module command_store #(
    parameter int DEPTH = 16,
    parameter int CMD_W = alu_pkg::CMD_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [CMD_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [CMD_W-1:0] rdata
);
    import alu_pkg::*;

    logic [CMD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= CMD_W'(HALT_CMD);
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/command_sequencer.sv
// Steps a stored program and hands commands to the ALU controller over valid/ready;
// HALT opcodes are consumed here and never issued.
module command_sequencer #(
    parameter int DEPTH = 16,
    parameter int CMD_W = alu_pkg::CMD_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [CMD_W-1:0] load_data,
    input  logic             start,
    input  logic             stop,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd,
    input  logic             cmd_ready,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             done
);
    import alu_pkg::*;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    seq_state_t       state, state_n;
    logic [AW-1:0]    pc_n, raddr;
    logic [CMD_W-1:0] cmd_n, rdata;
    logic             valid_n, done_n, we;

    assign we = load_en && (state == IDLE);

    command_store #(.DEPTH(DEPTH), .CMD_W(CMD_W), .AW(AW)) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    // One read port: entry 0 while idle, the prefetch slot pc+1 while running.
    // pc+1 wraps at LAST, but that case is decided by the pc compare first.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        cmd_n   = cmd;
        valid_n = cmd_valid;
        raddr   = (state == IDLE) ? '0 : AW'(pc + 1'b1);
        case (state)
            IDLE: begin
                if (start && !load_en) begin
                    pc_n = '0;
                    if (is_halt(rdata)) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        cmd_n   = rdata;
                        valid_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end else if (cmd_valid && cmd_ready) begin
                    if (pc == LAST || is_halt(rdata)) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                    end else begin
                        pc_n  = AW'(pc + 1'b1);
                        cmd_n = rdata;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            cmd       <= cmd_n;
            cmd_valid <= valid_n;
            done      <= done_n;
            busy      <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_command_sequencer.sv
// Directed bench: expected issued commands are queued as stimulus is applied and
// popped by a monitor on every handshake.
module tb_command_sequencer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n, load_en, start, stop, cmd_ready;
    logic [AW-1:0] load_addr;
    logic [11:0]   load_data;
    logic          cmd_valid, busy, done;
    logic [11:0]   cmd;
    logic [AW-1:0] pc;

    typedef struct { logic [11:0] c; logic [AW-1:0] p; } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    command_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .stop      (stop),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .pc        (pc),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [11:0] d);
        load_en = 1'b1; load_addr = AW'(a); load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic push(input logic [11:0] c, input int p);
        exp_t e;
        e.c = c; e.p = AW'(p);
        q.push_back(e);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("done_timeout", done, 1);
    endtask

    // Monitor: a handshake completes at the coming edge; sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done) done_cnt++;
            if (cmd_valid && cmd == 12'hE00) check("halt_issued", 1, 0);
            if (cmd_valid && cmd_ready) begin
                hs_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("issue_cmd", cmd, e.c);
                    check("issue_pc", pc, e.p);
                end
            end
        end
    end

    initial begin
        int cyc, hs0, dc0;
        int rdy [5]       = '{0, 0, 1, 0, 1};
        logic [11:0] ec [5] = '{12'h053, 12'h053, 12'h053, 12'h2D8, 12'h2D8};
        int ep [5]        = '{0, 0, 0, 1, 1};

        rst_n = 1'b0; load_en = 1'b0; start = 1'b0; stop = 1'b0; cmd_ready = 1'b0;
        load_addr = '0; load_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_valid", cmd_valid, 0);
        check("rst_cmd", cmd, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Two-command program, ready held high.
        load(0, 12'h053); load(1, 12'h2D8); load(2, 12'hE00);
        push(12'h053, 0); push(12'h2D8, 1);
        dc0 = done_cnt; hs0 = hs_cnt;
        cmd_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_first_valid", cmd_valid, 1);
        check("t1_first_cmd", cmd, 12'h053);
        wait_done(cyc);
        check("t1_done_latency", cyc, 2);
        check("t1_valid_at_done", cmd_valid, 0);
        tick();
        cmd_ready = 1'b0;
        check("t1_busy_after", busy, 0);
        check("t1_hs", hs_cnt - hs0, 2);
        check("t1_done_cnt", done_cnt - dc0, 1);

        // Same program with stalls.
        push(12'h053, 0); push(12'h2D8, 1);
        hs0 = hs_cnt; dc0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_ready = rdy[i][0];
            check("t2_cmd", cmd, ec[i]);
            check("t2_pc", pc, ep[i]);
            check("t2_valid", cmd_valid, 1);
            tick();
        end
        cmd_ready = 1'b0;
        check("t2_done", done, 1);
        tick();
        check("t2_hs", hs_cnt - hs0, 2);
        check("t2_done_cnt", done_cnt - dc0, 1);

        // Freshly reset design: HALT-first program.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_done", done, 1);
        check("t3_busy", busy, 1);
        check("t3_valid", cmd_valid, 0);
        tick();
        check("t3_done_clr", done, 0);
        check("t3_busy_clr", busy, 0);

        // Full-depth program: no wrap past the last entry.
        for (int i = 0; i < DEPTH; i++) load(i, 12'(i));
        for (int i = 0; i < DEPTH; i++) push(12'(i), i);
        hs0 = hs_cnt;
        cmd_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        check("t4_cycles", cyc, DEPTH);
        check("t4_pc_last", pc, DEPTH - 1);
        tick();
        cmd_ready = 1'b0;
        check("t4_hs", hs_cnt - hs0, DEPTH);
        check("t4_busy_after", busy, 0);

        // Stop during a stall at pc=1.
        push(12'h000, 0);
        dc0 = done_cnt; hs0 = hs_cnt;
        cmd_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cmd_ready = 1'b0;
        check("t5_stall_pc", pc, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_stop_valid", cmd_valid, 0);
        check("t5_stop_busy", busy, 0);
        tick(); tick();
        check("t5_no_done", done_cnt - dc0, 0);
        check("t5_hs", hs_cnt - hs0, 1);

        // Restart from 0, then stop together with a handshake.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_restart_pc", pc, 0);
        check("t5_restart_valid", cmd_valid, 1);
        hs0 = hs_cnt;
        push(12'h000, 0);
        cmd_ready = 1'b1; stop = 1'b1;
        tick();
        cmd_ready = 1'b0; stop = 1'b0;
        check("t5_stophs_valid", cmd_valid, 0);
        check("t5_stophs_busy", busy, 0);
        tick();
        check("t5_stophs_hs", hs_cnt - hs0, 1);
        check("t5_stophs_no_done", done_cnt - dc0, 0);

        // Reset mid-run while a command is presented.
        push(12'h000, 0); push(12'h001, 1);
        cmd_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        cmd_ready = 1'b0;
        check("t6_pre_valid", cmd_valid, 1);
        check("t6_pre_pc", pc, 2);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", cmd_valid, 0);
        check("t6_rst_cmd", cmd, 0);
        check("t6_rst_pc", pc, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_halt_done", done, 1);
        check("t6_halt_valid", cmd_valid, 0);
        tick();

        // Load and start together: load wins, start ignored.
        load_en = 1'b1; load_addr = '0; load_data = 12'h053; start = 1'b1;
        tick();
        load_en = 1'b0;
        check("t7_start_ignored", busy, 0);
        check("t7_no_valid", cmd_valid, 0);
        push(12'h053, 0);
        tick();
        start = 1'b0;
        check("t7_loaded_cmd", cmd, 12'h053);
        cmd_ready = 1'b1;
        wait_done(cyc);
        cmd_ready = 1'b0;
        check("t7_cycles", cyc, 1);
        tick(); tick();
        check("t7_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
